// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU request arbiter: opcode values, default widths
// and the arbiter FSM state encoding.
package alu_ctrl_pkg;

  localparam int ALU_DATA_W = 16;
  localparam int ALU_OP_W   = 3;

  localparam int ALU_OP_ADD = 0;
  localparam int ALU_OP_SUB = 1;
  localparam int ALU_OP_AND = 2;
  localparam int ALU_OP_OR  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: with both requesters valid, the
// one that did not win last time is chosen.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic any_valid
);

  always_comb begin
    any_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else begin
      grant = valid1;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin accept,
// one-cycle execute, held response. ALU_OP_CHECK_EN adds resp_err and blocks
// reserved opcodes from reaching the ALU.
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_cin,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_cin,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_cout,
  output logic              resp_lt,
  output logic              resp_eq,
  output logic              resp_gt,
`ifdef ALU_OP_CHECK_EN
  output logic              resp_err,
`endif
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [OP_W-1:0]   alu_opcod,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout,
  input  logic              alu_lt,
  input  logic              alu_eq,
  input  logic              alu_gt
);

  alu_state_e        state_reg, state_next;
  logic              last_grant_reg;
  logic              pending_id_reg;
  logic [DATA_W-1:0] alu_x_reg, alu_y_reg;
  logic [OP_W-1:0]   alu_opcod_reg;
  logic              alu_cin_reg;
  logic              resp_id_reg;
  logic [DATA_W-1:0] resp_data_reg;
  logic [3:0]        resp_flags_reg;

  logic              grant, any_valid, accept_slot, accept;
  logic [1:0]        req_valid, req_ready, grant_onehot;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic              sel_cin;

  rr_arb2 u_rr_arb2 (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_reg),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  assign accept_slot  = (state_reg == IDLE) || ((state_reg == RESP) && resp_ready);
  assign accept       = accept_slot && any_valid;
  assign req_valid    = {req1_valid, req0_valid};
  assign grant_onehot = {grant, ~grant};

  // The one-hot grant guarantees the two readies are never high together.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = accept_slot & req_valid[gi] & grant_onehot[gi];
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  assign sel_op  = grant ? req1_op  : req0_op;
  assign sel_a   = grant ? req1_a   : req0_a;
  assign sel_b   = grant ? req1_b   : req0_b;
  assign sel_cin = grant ? req1_cin : req0_cin;

`ifdef ALU_OP_CHECK_EN
  logic pending_err_reg;
  logic resp_err_reg;
  logic sel_legal;

  assign sel_legal = (sel_op <= OP_W'(ALU_OP_OR));
  assign resp_err  = resp_err_reg;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = EXEC;
      EXEC: state_next = RESP;
      RESP: if (resp_ready) state_next = accept ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      pending_id_reg <= 1'b0;
      alu_x_reg      <= '0;
      alu_y_reg      <= '0;
      alu_opcod_reg  <= '0;
      alu_cin_reg    <= 1'b0;
      resp_id_reg    <= 1'b0;
      resp_data_reg  <= '0;
      resp_flags_reg <= '0;
`ifdef ALU_OP_CHECK_EN
      pending_err_reg <= 1'b0;
      resp_err_reg    <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        last_grant_reg <= grant;
        pending_id_reg <= grant;
`ifdef ALU_OP_CHECK_EN
        pending_err_reg <= ~sel_legal;
        // Reserved ops never reach the ALU; its inputs keep the last legal op.
        if (sel_legal) begin
          alu_x_reg     <= sel_a;
          alu_y_reg     <= sel_b;
          alu_opcod_reg <= sel_op;
          alu_cin_reg   <= sel_cin;
        end
`else
        alu_x_reg     <= sel_a;
        alu_y_reg     <= sel_b;
        alu_opcod_reg <= sel_op;
        alu_cin_reg   <= sel_cin;
`endif
      end
      if (state_reg == EXEC) begin
        resp_id_reg <= pending_id_reg;
`ifdef ALU_OP_CHECK_EN
        if (pending_err_reg) begin
          resp_data_reg  <= '0;
          resp_flags_reg <= '0;
          resp_err_reg   <= 1'b1;
        end else begin
          resp_data_reg  <= alu_out;
          resp_flags_reg <= {alu_cout, alu_lt, alu_eq, alu_gt};
          resp_err_reg   <= 1'b0;
        end
`else
        resp_data_reg  <= alu_out;
        resp_flags_reg <= {alu_cout, alu_lt, alu_eq, alu_gt};
`endif
      end
    end
  end

  assign resp_valid = (state_reg == RESP);
  assign resp_id    = resp_id_reg;
  assign resp_data  = resp_data_reg;
  assign {resp_cout, resp_lt, resp_eq, resp_gt} = resp_flags_reg;
  assign alu_x      = alu_x_reg;
  assign alu_y      = alu_y_reg;
  assign alu_opcod  = alu_opcod_reg;
  assign alu_cin    = alu_cin_reg;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a behavioural ALU answers the arbiter, accepted
// requests push expected responses into a scoreboard popped on handshake.
module tb_alu_req_arbiter;
  import alu_ctrl_pkg::*;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [2:0]  req0_op;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [2:0]  req1_op;
  logic [15:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id;
  logic [15:0] resp_data;
  logic        resp_cout, resp_lt, resp_eq, resp_gt;
`ifdef ALU_OP_CHECK_EN
  logic        resp_err;
`endif
  logic [15:0] alu_x, alu_y, alu_out;
  logic [2:0]  alu_opcod;
  logic        alu_cin, alu_cout, alu_lt, alu_eq, alu_gt;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
    logic        cout, lt, eq, gt, err;
  } rsp_t;

  int   total = 0;
  int   bad   = 0;
  rsp_t sb[$];
  rsp_t obs;
  bit   got_resp, rv_seen, r0_seen, r1_seen, both_seen;

  alu_req_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_cout  (resp_cout),
    .resp_lt    (resp_lt),
    .resp_eq    (resp_eq),
    .resp_gt    (resp_gt),
`ifdef ALU_OP_CHECK_EN
    .resp_err   (resp_err),
`endif
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_opcod  (alu_opcod),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .alu_lt     (alu_lt),
    .alu_eq     (alu_eq),
    .alu_gt     (alu_gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {cout, lt, eq, gt, out}; reserved opcodes pass X through.
  function automatic logic [19:0] alu_f(input logic [2:0] op, input logic [15:0] x,
                                         input logic [15:0] y, input logic cin);
    logic [16:0] s;
    case (op)
      3'd0:    s = {1'b0, x} + {1'b0, y} + {16'd0, cin};
      3'd1:    s = {1'b0, x} + {1'b0, ~y} + 17'd1;
      3'd2:    s = {1'b0, x & y};
      3'd3:    s = {1'b0, x | y};
      default: s = {1'b0, x};
    endcase
    return {s[16], (x < y), (x == y), (x > y), s[15:0]};
  endfunction

  always_comb {alu_cout, alu_lt, alu_eq, alu_gt, alu_out} = alu_f(alu_opcod, alu_x, alu_y, alu_cin);

  function automatic rsp_t exp_of(input logic id, input logic [2:0] op, input logic [15:0] a,
                                  input logic [15:0] b, input logic cin);
    rsp_t r;
    r.id = id;
    {r.cout, r.lt, r.eq, r.gt, r.data} = alu_f(op, a, b, cin);
    r.err = 1'b0;
`ifdef ALU_OP_CHECK_EN
    if (op > 3'd3) begin
      r.data = '0;
      {r.cout, r.lt, r.eq, r.gt} = 4'b0000;
      r.err = 1'b1;
    end
`endif
    return r;
  endfunction

  // One clock: sample at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    r0_seen = req0_ready;
    r1_seen = req1_ready;
    if (req0_ready && req1_ready) both_seen = 1'b1;
    if (req0_ready) sb.push_back(exp_of(1'b0, req0_op, req0_a, req0_b, req0_cin));
    if (req1_ready) sb.push_back(exp_of(1'b1, req1_op, req1_a, req1_b, req1_cin));
    rv_seen  = resp_valid;
    got_resp = resp_valid && resp_ready;
    obs.id   = resp_id;
    obs.data = resp_data;
    {obs.cout, obs.lt, obs.eq, obs.gt} = {resp_cout, resp_lt, resp_eq, resp_gt};
`ifdef ALU_OP_CHECK_EN
    obs.err = resp_err;
`else
    obs.err = 1'b0;
`endif
    if (got_resp)
      $display("resp id=%0d data=%h cout=%0d lt=%0d eq=%0d gt=%0d err=%0d",
               obs.id, obs.data, obs.cout, obs.lt, obs.eq, obs.gt, obs.err);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int n, output int k);
    k = -1;
    for (int i = 1; i <= 20 && k < 0; i++) begin
      tick();
      if ((n == 0 && r0_seen) || (n == 1 && r1_seen)) k = i;
    end
  endtask

  task automatic wait_resp(output int k);
    k = -1;
    for (int i = 1; i <= 20 && k < 0; i++) begin
      tick();
      if (got_resp) k = i;
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic cin);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_cin = cin;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_cin = cin;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    resp_ready = 1'b0;
    set_req(0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
    set_req(1, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({resp_valid, resp_id, resp_data, resp_cout, resp_lt, resp_eq, resp_gt} !== 21'd0) begin
      bad++; $display("FAIL reset_resp got=%h want=0", resp_data);
    end
    total++;
    if ({alu_x, alu_y, alu_opcod, alu_cin} !== 36'd0) begin
      bad++; $display("FAIL reset_alu got x=%h y=%h op=%0d cin=%0d want 0", alu_x, alu_y, alu_opcod, alu_cin);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (rv_seen || r0_seen || r1_seen) begin
      bad++; $display("FAIL reset_idle got valid=%0d r0=%0d r1=%0d want 0", rv_seen, r0_seen, r1_seen);
    end
  endtask

  task automatic test_add();
    int k;
    rsp_t e;
    resp_ready = 1'b1;
    set_req(0, 1'b1, 3'(ALU_OP_ADD), 16'h7FFF, 16'h0001, 1'b0);
    wait_ready(0, k);
    req0_valid = 1'b0;
    total++;
    if (k < 0) begin bad++; $display("FAIL add_accept got=timeout want=ready"); end
    wait_resp(k);
    total++;
    if (k !== 2) begin bad++; $display("FAIL add_latency got=%0d want=2", k); end
    if (k > 0 && sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL add_sb got=%h want=%h", obs, e); end
      total++;
      if ({obs.id, obs.data, obs.cout} !== {1'b0, 16'h8000, 1'b0}) begin
        bad++; $display("FAIL add_const got id=%0d data=%h cout=%0d want id=0 data=8000 cout=0", obs.id, obs.data, obs.cout);
      end
    end
  endtask

  task automatic test_sub_and();
    int k;
    rsp_t e;
    resp_ready = 1'b1;
    set_req(1, 1'b1, 3'(ALU_OP_SUB), 16'h0005, 16'h0007, 1'b0);
    wait_ready(1, k);
    req1_valid = 1'b0;
    wait_resp(k);
    total++;
    if (k < 0 || sb.size() == 0) begin
      bad++; $display("FAIL sub_resp got=timeout want=response");
    end else begin
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL sub_sb got=%h want=%h", obs, e); end
      total++;
      if ({obs.id, obs.data, obs.lt, obs.eq, obs.gt} !== {1'b1, 16'hFFFE, 3'b100}) begin
        bad++; $display("FAIL sub_const got id=%0d data=%h lt/eq/gt=%0d%0d%0d want id=1 data=fffe 100",
                        obs.id, obs.data, obs.lt, obs.eq, obs.gt);
      end
    end
    set_req(1, 1'b1, 3'(ALU_OP_AND), 16'hF0F0, 16'h0FF0, 1'b0);
    wait_ready(1, k);
    req1_valid = 1'b0;
    wait_resp(k);
    total++;
    if (k < 0 || sb.size() == 0) begin
      bad++; $display("FAIL and_resp got=timeout want=response");
    end else begin
      e = sb.pop_front();
      total++;
      if (obs !== e || obs.data !== 16'h00F0) begin
        bad++; $display("FAIL and_data got=%h want=%h (data 00f0)", obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int grants[$];
    int last_t, n_resp;
    rsp_t e;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    sb.delete();
    both_seen  = 1'b0;
    last_t     = -1;
    n_resp     = 0;
    resp_ready = 1'b1;
    set_req(0, 1'b1, 3'(ALU_OP_ADD), 16'h1000, 16'h0234, 1'b1);
    set_req(1, 1'b1, 3'(ALU_OP_OR),  16'h00F0, 16'h0F00, 1'b0);
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (r0_seen) grants.push_back(0);
      if (r1_seen) grants.push_back(1);
      if (got_resp) begin
        n_resp++;
        if (last_t >= 0) begin
          total++;
          if (t - last_t !== 2) begin bad++; $display("FAIL b2b_gap got=%0d want=2", t - last_t); end
        end
        last_t = t;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          total++;
          if (obs !== e) begin bad++; $display("FAIL b2b_sb got=%h want=%h", obs, e); end
        end
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    total++;
    if (grants.size() !== 7) begin bad++; $display("FAIL b2b_grants got=%0d want=7", grants.size()); end
    for (int i = 0; i < grants.size(); i++) begin
      total++;
      if (grants[i] !== i % 2) begin bad++; $display("FAIL b2b_order[%0d] got=%0d want=%0d", i, grants[i], i % 2); end
    end
    total++;
    if (n_resp !== 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", n_resp); end
    total++;
    if (both_seen) begin bad++; $display("FAIL b2b_both_ready got=1 want=0"); end
    while (sb.size() > 0) begin
      int k;
      wait_resp(k);
      e = sb.pop_front();
      total++;
      if (k < 0 || obs !== e) begin bad++; $display("FAIL b2b_drain got=%h want=%h", obs, e); end
    end
  endtask

  task automatic test_stall();
    int k;
    rsp_t e;
    resp_ready = 1'b0;
    set_req(0, 1'b1, 3'(ALU_OP_OR), 16'h1234, 16'h00FF, 1'b0);
    wait_ready(0, k);
    req0_valid = 1'b0;
    k = -1;
    for (int i = 1; i <= 20 && k < 0; i++) begin
      tick();
      if (rv_seen) k = i;
    end
    total++;
    if (k !== 2) begin bad++; $display("FAIL stall_latency got=%0d want=2", k); end
    set_req(1, 1'b1, 3'(ALU_OP_AND), 16'h0F0F, 16'hFFFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (!rv_seen || obs.data !== 16'h12FF || r0_seen || r1_seen) begin
        bad++; $display("FAIL stall_hold[%0d] got valid=%0d data=%h r0=%0d r1=%0d want 1 12ff 0 0",
                        i, rv_seen, obs.data, r0_seen, r1_seen);
      end
    end
    resp_ready = 1'b1;
    tick();
    req1_valid = 1'b0;
    total++;
    if (!got_resp || !r1_seen) begin
      bad++; $display("FAIL stall_release got resp=%0d r1=%0d want 1 1", got_resp, r1_seen);
    end
    if (got_resp && sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL stall_sb got=%h want=%h", obs, e); end
    end
    wait_resp(k);
    total++;
    if (k !== 2 || sb.size() == 0) begin
      bad++; $display("FAIL stall_next got=%0d want=2", k);
    end else begin
      e = sb.pop_front();
      total++;
      if (obs !== e || obs.data !== 16'h0F0F) begin bad++; $display("FAIL stall_next_sb got=%h want=%h", obs, e); end
    end
  endtask

  task automatic test_reset_mid();
    int k, stale;
    rsp_t e;
    resp_ready = 1'b1;
    set_req(1, 1'b1, 3'(ALU_OP_SUB), 16'h0100, 16'h0001, 1'b1);
    wait_ready(1, k);
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (resp_valid !== 1'b0 || {alu_x, alu_y, alu_opcod, alu_cin} !== 36'd0) begin
      bad++; $display("FAIL midrst_async got valid=%0d x=%h y=%h op=%0d cin=%0d want all 0",
                      resp_valid, alu_x, alu_y, alu_opcod, alu_cin);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rv_seen) stale++;
    end
    total++;
    if (stale !== 0) begin bad++; $display("FAIL midrst_stale got=%0d want=0", stale); end
    set_req(0, 1'b1, 3'(ALU_OP_ADD), 16'h0003, 16'h0004, 1'b1);
    set_req(1, 1'b1, 3'(ALU_OP_OR),  16'h0100, 16'h0010, 1'b0);
    wait_ready(0, k);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    total++;
    if (k !== 1) begin bad++; $display("FAIL midrst_first_grant got=%0d want=1 (req0 first)", k); end
    sb.delete();
    sb.push_back(exp_of(1'b0, 3'(ALU_OP_ADD), 16'h0003, 16'h0004, 1'b1));
    wait_resp(k);
    total++;
    if (k < 0) begin
      bad++; $display("FAIL midrst_resp got=timeout want=response");
    end else begin
      e = sb.pop_front();
      total++;
      if (obs !== e || obs.data !== 16'h0008) begin bad++; $display("FAIL midrst_sb got=%h want=%h", obs, e); end
    end
  endtask

  task automatic test_reserved();
    int k;
    rsp_t e;
    resp_ready = 1'b1;
    set_req(0, 1'b1, 3'(ALU_OP_AND), 16'h00FF, 16'h0F0F, 1'b0);
    wait_ready(0, k);
    req0_valid = 1'b0;
    wait_resp(k);
    if (sb.size() > 0) e = sb.pop_front();
    set_req(0, 1'b1, 3'd5, 16'h0005, 16'h0003, 1'b1);
    wait_ready(0, k);
    req0_valid = 1'b0;
`ifdef ALU_OP_CHECK_EN
    total++;
    if (alu_opcod !== 3'd2 || alu_x !== 16'h00FF) begin
      bad++; $display("FAIL rsv_alu_hold got op=%0d x=%h want op=2 x=00ff", alu_opcod, alu_x);
    end
`else
    total++;
    if (alu_opcod !== 3'd5 || alu_x !== 16'h0005) begin
      bad++; $display("FAIL rsv_alu_pass got op=%0d x=%h want op=5 x=0005", alu_opcod, alu_x);
    end
`endif
    wait_resp(k);
    total++;
    if (k !== 2 || sb.size() == 0) begin
      bad++; $display("FAIL rsv_latency got=%0d want=2", k);
    end else begin
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL rsv_sb got=%h want=%h", obs, e); end
`ifdef ALU_OP_CHECK_EN
      total++;
      if (obs.data !== 16'h0000 || obs.err !== 1'b1) begin
        bad++; $display("FAIL rsv_err got data=%h err=%0d want 0000 1", obs.data, obs.err);
      end
`else
      total++;
      if (obs.data !== 16'h0005) begin bad++; $display("FAIL rsv_data got=%h want=0005", obs.data); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_and();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_reserved();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares the single combinational 16-bit ALU (add/sub/and/or plus compare flags) between two requesters.
- Arbitrates round-robin, registers the winning operation, drives the ALU operand/opcode inputs, and captures its result.
- Returns the result with a valid/ready response tagged by requester ID.
- Sits between the datapath control units and the ALU instance.

Parameters:
DATA_W, 16, operand/result width (must match ALU X/Y/out)
OP_W, 3, opcode width (must match ALU opcod)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_op  in  OP_W  opcode: 0 add, 1 sub, 2 and, 3 or, 4-7 reserved
req0_a, req0_b  in  DATA_W  operands
req0_cin  in  1  carry-in (used by add)
req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_cin  same as requester 0
resp_valid  out  1  response held
resp_ready  in  1  consumer takes response
resp_id  out  1  requester that issued the op
resp_data  out  DATA_W  ALU out
resp_cout  out  1  ALU Cout
resp_lt, resp_eq, resp_gt  out  1  ALU compare flags
alu_x, alu_y  out  DATA_W  to ALU X/Y
alu_opcod  out  OP_W  to ALU opcod
alu_cin  out  1  to ALU Cin
alu_out  in  DATA_W  from ALU
alu_cout, alu_lt, alu_eq, alu_gt  in  1  from ALU

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low. All state is flopped on the rising clk edge except the ready outputs, which are combinational.
- Reset values:
  - state=IDLE, all resp_* = 0, alu_x/alu_y/alu_opcod/alu_cin = 0.
  - last_grant=1, so requester 0 wins the first contention.
- FSM states:
  - IDLE: waiting for a request.
  - EXEC: ALU inputs stable for one full cycle.
  - RESP: resp_valid=1.
- Accept slot: accept_slot = (state==IDLE) or (state==RESP and resp_ready).
- Grant:
  - Only one valid requester: it wins.
  - Both valid: the requester not equal to last_grant wins.
  - reqN_ready = accept_slot and reqN_valid and grant==N. Never both high.
- On accept:
  - Latch op/a/b/cin into alu_opcod/alu_x/alu_y/alu_cin.
  - Latch grant into last_grant and the pending ID.
  - Next state EXEC.
- EXEC:
  - ALU combinational outputs are sampled at the end of the cycle into resp_data/cout/lt/eq/gt/id.
  - Next state RESP. EXEC is never stalled.
- RESP:
  - resp_* held constant while resp_ready=0.
  - resp_ready=1 with an accept in the same cycle: go to EXEC (back-to-back).
  - resp_ready=1 with no request: go to IDLE, resp_valid drops next cycle.
- Latency and throughput:
  - Latency is accept edge to resp_valid = 2 cycles.
  - Peak throughput is 1 op per 2 cycles.
- ALU inputs retain the last op when idle; they change only on accept.
- Requester rules: a requester must hold valid/op/a/b/cin stable until ready. The arbiter does not check this.
- Carry: sub ignores alu_cin (the ALU forces its own carry for subtract); alu_cin is still driven from the request.
- Reset mid-operation: any op in EXEC/RESP is discarded with no response; outputs return to reset values immediately.
- Priority: last_grant updates only on accept, so a held-off requester wins the next contention. No starvation.

Optional Feature:
- Macro ALU_OP_CHECK_EN.
- Defined:
  - Adds output resp_err (1 bit, reset 0).
  - Opcodes 4-7 are still accepted and take the same 2-cycle path, but alu_x/alu_y/alu_opcod/alu_cin are not updated.
  - The response carries resp_data=0, cout/lt/eq/gt=0, resp_err=1.
  - Legal ops give resp_err=0.
- Undefined:
  - No resp_err port.
  - Reserved opcodes pass straight to the ALU; the response is whatever the ALU returns.

Decomposition:
- Package alu_ctrl_pkg:
  - Opcode constants ALU_OP_ADD=0, ALU_OP_SUB=1, ALU_OP_AND=2, ALU_OP_OR=3.
  - DATA_W/OP_W defaults.
  - FSM state encoding IDLE/EXEC/RESP.
- Sub-module rr_arb2: a combinational 2-way round-robin picker. Inputs are two valids and last_grant; outputs are grant and any_valid.

Test Plan:
1. req0 add a=0x7FFF b=0x0001 cin=0, resp_ready=1 -> resp_valid 2 cycles after accept; data=0x8000, cout=0, id=0.
2. req1 sub a=0x0005 b=0x0007 -> data=0xFFFE, lt=1, eq=0, gt=0, id=1. Then and 0xF0F0/0x0FF0 -> 0x00F0.
3. Both valid from reset with continuous requests and resp_ready=1 -> grants alternate 0,1,0,1; responses back-to-back every 2 cycles; never both readys high.
4. resp_ready=0 for 5 cycles in RESP (or 0x1234/0x00FF) -> resp_data=0x12FF held; no ready asserted; accept occurs on the first resp_ready=1 cycle.
5. rst_n low mid-EXEC -> resp_valid=0 and alu_* = 0 immediately. No stale response after release. First contention goes to req0.
6. ALU_OP_CHECK_EN defined, op=5 -> resp_err=1, data=0, alu_opcod unchanged from the prior op. Undefined, op=5 -> resp_data=0x0005.
